seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits; legal values are powers of two, 8 to 64.
REQ-002 Parameter MUL_EN, default 1, SHALL include the iterative multiplier when 1; when 0, op 0101 SHALL behave as add.
REQ-003 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 in_valid  in  1  SHALL indicate that the operation request is valid.
REQ-006 in_ready  out  1  SHALL indicate that the block can accept a request.
REQ-007 a, b  in  WIDTH (signed)  SHALL carry the operands; b[log2(WIDTH)-1:0] is the shift/rotate amount.
REQ-008 op  in  4  SHALL carry the opcode.
REQ-009 out_valid  out  1  SHALL indicate that the result is valid.
REQ-010 out_ready  in  1  SHALL indicate that the consumer accepts the result.
REQ-011 result  out  WIDTH  SHALL carry the registered result.
REQ-012 zero  out  1  SHALL be 1 when result == 0.
REQ-013 ovf  out  1  SHALL be the signed overflow flag for add/sub and 0 for all other ops.

Function
REQ-014 Opcodes SHALL be:
- 0000 add; 0001 sub; 0010 and; 0011 or; 0100 not a; 0101 mul (low WIDTH bits); 0110 xor
- 1000 arithmetic shift right; 1001 shift left logical; 1010 shift right logical; 1100 rotate left; 1101 rotate right
- any other opcode: add
REQ-015 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur on in_valid && in_ready; a, b and op are latched, and the state moves IDLE->EXEC.
REQ-018 On accept, the step counter SHALL load as follows:
- logic/arith ops: 0
- shifts/rotates: b[log2(WIDTH)-1:0]
- mul: WIDTH
REQ-019 In EXEC, while count > 0, the block SHALL perform one step per cycle and decrement count:
- shift/rotate: one bit position per step
- mul: one shift-add step, multiplicand shifted left, multiplier shifted right
REQ-020 In EXEC with count == 0, the block SHALL compute the final result, zero and ovf, register them, and move to DONE.
REQ-021 Latency SHALL be n+1 cycles from the accept edge to out_valid, where n is the loaded count; a shift or rotate by 0 returns a unchanged at latency 1.
REQ-022 In DONE, result, zero and ovf SHALL hold stable until out_ready = 1; then the state moves DONE->IDLE.
REQ-023 No new request SHALL be accepted in the same cycle a result is consumed.
REQ-024 ovf SHALL be computed as follows:
- add: (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB])
- sub: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; mul SHALL return the low WIDTH bits of the product of the operands treated as unsigned.
REQ-026 in_valid asserted outside IDLE SHALL be ignored, with no side effects.

Reset
REQ-027 While reset = 1, the block SHALL be in state IDLE with count = 0 and result, zero, ovf and out_valid = 0; in_ready SHALL be 1 in IDLE.
REQ-028 Reset asserted in EXEC or DONE SHALL abort the operation immediately, and the result SHALL be discarded.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants, the FSM state type and the function log2(WIDTH).
REQ-030 Sub-module alu_core SHALL implement the single-cycle combinational ops (add, sub, and, or, not, xor) and ovf; the FSM, counter, shifter and multiplier datapath SHALL reside in seq_alu.

Verification
REQ-031 The bench SHALL cover the following directed scenarios at WIDTH = 32:
- add a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1, zero=0, out_valid 1 cycle after accept
- sub a=5, b=5 -> result 0, zero=1, ovf=0
- op 1000, a=0x80000000, b=4 -> result 0xF8000000, out_valid 5 cycles after accept; op 1101, a=1, b=1 -> 0x80000000
- op 1100, a=0x80000001, b=0 -> result 0x80000001 at latency 1; op 0111 (undefined), a=2, b=3 -> result 5
- mul a=0xFFFFFFFF, b=3 -> result 0xFFFFFFFD at latency 33; out_ready held low 3 cycles -> result stable, in_ready=0
- reset pulsed 10 cycles into a mul -> out_valid=0, result=0, in_ready=1; the next add 1+1 returns 2

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state type and
// compile-time helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_ASR = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1100;
  localparam logic [3:0] OP_ROR = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_ASR) || (op == OP_SLL) || (op == OP_SRL) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ops (add, sub, and, or, not, xor) and the signed
// overflow flag; unrecognised opcodes fall back to add.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum     = a_i + b_i;
  assign diff    = a_i - b_i;
  assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1]  != a_i[WIDTH-1]);
  assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    result_o = sum;
    ovf_o    = add_ovf;
    case (op_i)
      OP_SUB: begin
        result_o = diff;
        ovf_o    = sub_ovf;
      end
      OP_AND: begin
        result_o = a_i & b_i;
        ovf_o    = 1'b0;
      end
      OP_OR: begin
        result_o = a_i | b_i;
        ovf_o    = 1'b0;
      end
      OP_NOT: begin
        result_o = ~a_i;
        ovf_o    = 1'b0;
      end
      OP_XOR: begin
        result_o = a_i ^ b_i;
        ovf_o    = 1'b0;
      end
      default: begin
        result_o = sum;
        ovf_o    = add_ovf;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: IDLE/EXEC/DONE handshake FSM with a bit-serial shifter and
// an iterative shift-add multiplier; single-cycle ops come from alu_core.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [3:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        result,
  output logic                    zero,
  output logic                    ovf
);

  localparam int SHW = log2(WIDTH);
  localparam int CW  = SHW + 1;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] core_result;
  logic             core_ovf;
  logic             in_is_shift;
  logic             in_is_mul;
  logic             q_is_shift;
  logic             q_is_mul;
  logic [WIDTH-1:0] shift_step;
  logic [WIDTH-1:0] final_result;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (opa_q),
    .b_i      (opb_q),
    .op_i     (op_q),
    .result_o (core_result),
    .ovf_o    (core_ovf)
  );

  // With the multiplier excluded, op 0101 is left to alu_core, which adds.
  assign in_is_shift = is_shift_op(op);
  assign in_is_mul   = MUL_EN && (op == OP_MUL);
  assign q_is_shift  = is_shift_op(op_q);
  assign q_is_mul    = MUL_EN && (op_q == OP_MUL);

  always_comb begin
    shift_step = opa_q;
    case (op_q)
      OP_ASR:  shift_step = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
      OP_SLL:  shift_step = {opa_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, opa_q[WIDTH-1:1]};
      OP_ROL:  shift_step = {opa_q[WIDTH-2:0], opa_q[WIDTH-1]};
      OP_ROR:  shift_step = {opa_q[0], opa_q[WIDTH-1:1]};
      default: shift_step = opa_q;
    endcase
  end

  assign final_result = q_is_shift ? opa_q : (q_is_mul ? acc_q : core_result);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_EXEC;
          op_d    = op;
          opa_d   = a;
          opb_d   = b;
          acc_d   = '0;
          if (in_is_shift)    count_d = {{(CW-SHW){1'b0}}, b[SHW-1:0]};
          else if (in_is_mul) count_d = CW'(WIDTH);
          else                count_d = '0;
        end
      end
      ST_EXEC: begin
        if (count_q != '0) begin
          count_d = count_q - CW'(1);
          if (q_is_mul) begin
            if (opb_q[0]) acc_d = acc_q + opa_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
          end else begin
            opa_d = shift_step;
          end
        end else begin
          state_d  = ST_DONE;
          result_d = final_result;
          zero_d   = (final_result == '0);
          ovf_d    = (q_is_shift || q_is_mul) ? 1'b0 : core_ovf;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule
